// File: rtl/sha256_pkg.sv
// Constants, state encoding and bit-mixing helpers shared by the streaming SHA-256/224 core.
package sha256_pkg;

    typedef logic [0:7][31:0] hash_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_PAD, ST_COMP, ST_UPDATE, ST_DONE
    } state_e;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hash_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Final word: keep the valid MSB-aligned bytes and drop the 0x80 marker right after them.
    function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [2:0] nb);
        case (nb)
            3'd0:    return 32'h8000_0000;
            3'd1:    return {d[31:24], 24'h80_0000};
            3'd2:    return {d[31:16], 16'h8000};
            3'd3:    return {d[31:8], 8'h80};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// Message-in / digest-out bundle of the streaming hash core; master = message source, slave = core.
interface sha256_stream_if;
    import sha256_pkg::*;

    logic        start;
    logic        mode_224;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        busy;
    logic        digest_valid;
    hash_t       digest;

    modport master (
        output start, mode_224, in_valid, in_data, in_last, in_bytes,
        input  in_ready, busy, digest_valid, digest
    );

    modport slave (
        input  start, mode_224, in_valid, in_data, in_last, in_bytes,
        output in_ready, busy, digest_valid, digest
    );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: a..h plus W_t and K_t in, next a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t       work_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output hash_t       work_o
);
    logic [31:0] t1, t2;

    always_comb begin
        t1 = work_i[7] + big_sigma1(work_i[4]) + ch(work_i[4], work_i[5], work_i[6]) + k_i + w_i;
        t2 = big_sigma0(work_i[0]) + maj(work_i[0], work_i[1], work_i[2]);
        work_o = {t1 + t2, work_i[0:2], work_i[3] + t1, work_i[4:6]};
    end
endmodule

// File: rtl/sha256_stream.sv
// Streaming multi-block SHA-256/224: 16 load/pad cycles + 64 rounds + 1 update per block, digest held in DONE.
// Backpressure: in_ready is high only in LOAD; words offered in any other state are left unconsumed.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int LEN_W     = 64,
    parameter bit SHA224_EN = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    sha256_stream_if.slave s
);
    state_e            state_q, state_d;
    hash_t             h_q, h_d, v_q, v_d, v_rnd, digest_q, digest_d;
    logic [0:15][31:0] w_q, w_d;
    logic [3:0]        idx_q, idx_d;
    logic [5:0]        rnd_q, rnd_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mode_q, mode_d;
    logic              in_done_q, in_done_d;
    logic              need80_q, need80_d;
    logic              final_q, final_d;
    logic [63:0]       len64;
    logic [31:0]       w_new;

    assign len64 = 64'(len_q);
    assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    sha256_round u_round (
        .work_i (v_q),
        .w_i    (w_q[0]),
        .k_i    (K[rnd_q]),
        .work_o (v_rnd)
    );

    assign s.in_ready     = (state_q == ST_LOAD);
    assign s.busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign s.digest_valid = (state_q == ST_DONE);
    assign s.digest       = digest_q;

    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        w_d       = w_q;
        idx_d     = idx_q;
        rnd_d     = rnd_q;
        len_d     = len_q;
        mode_d    = mode_q;
        in_done_d = in_done_q;
        need80_d  = need80_q;
        final_d   = final_q;
        digest_d  = digest_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (s.start) begin
                    mode_d    = SHA224_EN && s.mode_224;
                    h_d       = mode_d ? IV224 : IV256;
                    v_d       = h_d;
                    len_d     = '0;
                    idx_d     = '0;
                    rnd_d     = '0;
                    in_done_d = 1'b0;
                    need80_d  = 1'b0;
                    final_d   = 1'b0;
                    digest_d  = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (s.in_valid) begin
                    len_d = len_q + LEN_W'({s.in_bytes, 3'b000});
                    idx_d = idx_q + 4'd1;
                    if (s.in_last) begin
                        w_d[idx_q] = pad_last(s.in_data, s.in_bytes);
                        in_done_d  = 1'b1;
                        need80_d   = (s.in_bytes >= 3'd4);
                        state_d    = (idx_q == 4'd15) ? ST_COMP : ST_PAD;
                    end else begin
                        w_d[idx_q] = s.in_data;
                        if (idx_q == 4'd15) state_d = ST_COMP;
                    end
                end
            end
            ST_PAD: begin
                idx_d = idx_q + 4'd1;
                // Length only lands at word 14 if the 0x80 marker is already behind us in this block.
                if (need80_q) begin
                    w_d[idx_q] = 32'h8000_0000;
                    need80_d   = 1'b0;
                end else if (idx_q == 4'd14) begin
                    w_d[idx_q] = len64[63:32];
                    final_d    = 1'b1;
                end else if (idx_q == 4'd15 && final_q) begin
                    w_d[idx_q] = len64[31:0];
                end else begin
                    w_d[idx_q] = '0;
                end
                if (idx_q == 4'd15) state_d = ST_COMP;
            end
            ST_COMP: begin
                v_d   = v_rnd;
                w_d   = {w_q[1:15], w_new};
                rnd_d = rnd_q + 6'd1;
                if (rnd_q == 6'd63) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                v_d = h_d;
                if (final_q) begin
                    digest_d = mode_q ? {h_d[0:6], 32'h0} : h_d;
                    state_d  = ST_DONE;
                end else begin
                    state_d = in_done_q ? ST_PAD : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            w_q       <= '0;
            idx_q     <= '0;
            rnd_q     <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            in_done_q <= 1'b0;
            need80_q  <= 1'b0;
            final_q   <= 1'b0;
            digest_q  <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            w_q       <= w_d;
            idx_q     <= idx_d;
            rnd_q     <= rnd_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            in_done_q <= in_done_d;
            need80_q  <= need80_d;
            final_q   <= final_d;
            digest_q  <= digest_d;
        end
    end
endmodule
